frame_buffer_arbiter: RTL

// Shares one single-port frame-buffer BRAM between the camera capture writer and the VGA pixel fetch.

---
 rtl/frame_buffer_arbiter_pkg.sv | 18 +
 rtl/frame_buffer_arbiter_wr_fifo.sv | 68 ++++++
 rtl/frame_buffer_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/frame_buffer_arbiter_pkg.sv
// Shared definitions for the frame-buffer arbiter: grant encodings and default widths.
package frame_buffer_arbiter_pkg;

  localparam int FB_ADDR_WIDTH = 17;
  localparam int FB_DATA_WIDTH = 9;
  localparam int FB_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } gnt_e;

  function automatic logic gnt_is_active(input gnt_e g);
    return (g == GNT_RD) || (g == GNT_WR);
  endfunction

endpackage

// File: rtl/frame_buffer_arbiter_wr_fifo.sv
// Synchronous write FIFO with first-word-fall-through head, {addr,data} payload.
module frame_buffer_arbiter_wr_fifo
  import frame_buffer_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int DEPTH      = FB_FIFO_DEPTH
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Push,
  input  logic [ADDR_WIDTH-1:0]    i_Push_Addr,
  input  logic [DATA_WIDTH-1:0]    i_Push_Data,
  input  logic                     i_Pop,
  output logic [ADDR_WIDTH-1:0]    o_Head_Addr,
  output logic [DATA_WIDTH-1:0]    o_Head_Data,
  output logic [$clog2(DEPTH):0]   o_Level,
  output logic                     o_Full,
  output logic                     o_Empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PAY_W = ADDR_WIDTH + DATA_WIDTH;

  logic [PAY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  // Full/empty come only from the registered level, so a same-cycle pop never frees a slot.
  assign o_Full  = (r_level == LVL_W'(DEPTH));
  assign o_Empty = (r_level == LVL_W'(0));
  assign w_push  = i_Push && !o_Full;
  assign w_pop   = i_Pop && !o_Empty;

  assign o_Level = r_level;
  assign {o_Head_Addr, o_Head_Data} = r_mem[r_rd_ptr];

  always_ff @(posedge i_Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_Push_Addr, i_Push_Data};
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_level  <= LVL_W'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame-buffer arbiter: fixed-latency priority reads, FIFO-buffered writes drained when idle.
module frame_buffer_arbiter
  import frame_buffer_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int FIFO_DEPTH = FB_FIFO_DEPTH
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset,
  input  logic                        i_Wr_Valid,
  output logic                        o_Wr_Ready,
  input  logic [ADDR_WIDTH-1:0]       i_Wr_Addr,
  input  logic [DATA_WIDTH-1:0]       i_Wr_Data,
  input  logic                        i_Rd_Req,
  input  logic [ADDR_WIDTH-1:0]       i_Rd_Addr,
  output logic [DATA_WIDTH-1:0]       o_Rd_Data,
  output logic                        o_Rd_Valid,
  output logic                        o_Mem_En,
  output logic                        o_Mem_We,
  output logic [ADDR_WIDTH-1:0]       o_Mem_Addr,
  output logic [DATA_WIDTH-1:0]       o_Mem_Wdata,
  input  logic [DATA_WIDTH-1:0]       i_Mem_Rdata,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Level,
  input  logic                        i_Clear_Flags,
  output logic                        o_Overflow
);

  gnt_e                  r_gnt;
  gnt_e                  w_gnt_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [1:0]            r_rd_pipe;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_fifo_pop;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;

  frame_buffer_arbiter_wr_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_wr_fifo (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Push      (i_Wr_Valid),
    .i_Push_Addr (i_Wr_Addr),
    .i_Push_Data (i_Wr_Data),
    .i_Pop       (w_fifo_pop),
    .o_Head_Addr (w_head_addr),
    .o_Head_Data (w_head_data),
    .o_Level     (o_Fifo_Level),
    .o_Full      (w_fifo_full),
    .o_Empty     (w_fifo_empty)
  );

  assign o_Wr_Ready = !w_fifo_full;
  assign w_fifo_pop = (w_gnt_nxt == GNT_WR);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_gnt <= GNT_NONE;
    end else begin
      r_gnt <= w_gnt_nxt;
    end
  end

  // Reads always win so the pixel stream keeps its fixed latency.
  always_comb begin
    w_gnt_nxt = GNT_NONE;
    if (i_Rd_Req) begin
      w_gnt_nxt = GNT_RD;
    end else if (!w_fifo_empty) begin
      w_gnt_nxt = GNT_WR;
    end else begin
      w_gnt_nxt = GNT_NONE;
    end
  end

  always_comb begin
    o_Mem_En    = gnt_is_active(r_gnt);
    o_Mem_We    = (r_gnt == GNT_WR);
    o_Mem_Addr  = r_mem_addr;
    o_Mem_Wdata = r_mem_wdata;
  end

  // Idle cycles keep the last address/data on the BRAM bus.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_mem_addr  <= ADDR_WIDTH'(0);
      r_mem_wdata <= DATA_WIDTH'(0);
    end else begin
      case (w_gnt_nxt)
        GNT_RD: begin
          r_mem_addr <= i_Rd_Addr;
        end
        GNT_WR: begin
          r_mem_addr  <= w_head_addr;
          r_mem_wdata <= w_head_data;
        end
        default: begin
          r_mem_addr  <= r_mem_addr;
          r_mem_wdata <= r_mem_wdata;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_rd_pipe  <= 2'b00;
      o_Rd_Valid <= 1'b0;
      o_Rd_Data  <= DATA_WIDTH'(0);
    end else begin
      r_rd_pipe  <= {r_rd_pipe[0], i_Rd_Req};
      o_Rd_Valid <= r_rd_pipe[1];
      if (r_rd_pipe[1]) begin
        o_Rd_Data <= i_Mem_Rdata;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Overflow <= 1'b0;
    end else if (i_Clear_Flags) begin
      o_Overflow <= 1'b0;
    end else if (i_Wr_Valid && w_fifo_full) begin
      o_Overflow <= 1'b1;
    end
  end

endmodule
